// File: rtl/nic8_ctl_pkg.sv
// Shared definitions for the nic8 control sequencer: phase states, bus source
// and destination codes, and IR condition-bit positions.
package nic8_ctl_pkg;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} seqState_e;

  typedef enum logic [2:0] {
    SRC_ROM = 3'd0,
    SRC_RAM = 3'd1,
    SRC_A   = 3'd2,
    SRC_X   = 3'd3,
    SRC_E   = 3'd4
  } srcCode_e;

  typedef enum logic [2:0] {
    DEST_NOP = 3'd0,
    DEST_PC  = 3'd1,
    DEST_A   = 3'd2,
    DEST_B   = 3'd3,
    DEST_X   = 3'd4,
    DEST_MEM = 3'd5,
    DEST_Q   = 3'd6
  } destCode_e;

  // The two condition bits sit directly above the source/dest fields.
  function automatic int irCarryBit(input int srcW, input int dstW);
    return srcW + dstW + 1;
  endfunction

  function automatic int irZeroBit(input int srcW, input int dstW);
    return srcW + dstW;
  endfunction

endpackage

// File: rtl/control_seq_jump.sv
// Jump condition for the nic8 sequencer: combines the IR condition bits with
// the flags as they stood before the current instruction.
module control_seq_jump (
  input  logic condC,
  input  logic condZ,
  input  logic flagC,
  input  logic flagZ,
  output logic jcond
);

  // Both condition bits set means an unconditional jump.
  assign jcond = (condC & condZ) | (condZ & flagZ) | (condC & flagC);

endmodule

// File: rtl/control_seq.sv
// nic8 FETCH/DECODE/EXEC control sequencer with registered carry/zero flags.
// Optional HALT state is enabled by defining CONTROL_SEQ_HALT_EN.
module control_seq
  import nic8_ctl_pkg::*;
#(
  parameter int SRC_W    = 3,
  parameter int DST_W    = 3,
  parameter int NUM_SRC  = 5,
  parameter int NUM_DEST = 7,
  parameter int A_DEST   = int'(DEST_A),
  parameter int PC_DEST  = int'(DEST_PC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2+SRC_W+DST_W-1:0] ir,
  input  logic                     mem_ready,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  output logic                     load_ir,
  output logic                     pc_inc,
  output logic [NUM_DEST-1:0]      load_en,
  output logic [NUM_SRC-1:0]       src_n,
  output logic                     do_sub,
  output logic                     do_jump,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     halted
);

  localparam int CBIT = irCarryBit(SRC_W, DST_W);
  localparam int ZBIT = irZeroBit(SRC_W, DST_W);

  seqState_e        state;
  seqState_e        stateNext;
  logic [SRC_W-1:0] srcReg;
  logic [DST_W-1:0] dstReg;
  logic             jcond;
  logic             memSrc;
  logic             isHaltDst;
  logic             flagLoad;

  control_seq_jump uJump (
    .condC (ir[CBIT]),
    .condZ (ir[ZBIT]),
    .flagC (flag_c),
    .flagZ (flag_z),
    .jcond (jcond)
  );

  assign memSrc = (srcReg == SRC_W'(SRC_ROM)) || (srcReg == SRC_W'(SRC_RAM));

`ifdef CONTROL_SEQ_HALT_EN
  assign isHaltDst = (dstReg == {DST_W{1'b1}});
  assign halted    = (state == HALT) && !reset;
`else
  assign isHaltDst = 1'b0;
  assign halted    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      srcReg <= '0;
      dstReg <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == DECODE) begin
        srcReg <= ir[SRC_W+DST_W-1:DST_W];
        dstReg <= ir[DST_W-1:0];
      end
      if (flagLoad) begin
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end
    end
  end

  always_comb begin
    stateNext = state;
    load_ir   = 1'b0;
    pc_inc    = 1'b0;
    load_en   = '0;
    src_n     = '1;
    do_sub    = 1'b0;
    do_jump   = 1'b0;
    flagLoad  = 1'b0;
    // Reset suppresses every pulse in the cycle it is asserted.
    if (reset) begin
      stateNext = FETCH;
    end else begin
      case (state)
        FETCH: begin
          src_n[int'(SRC_ROM)] = 1'b0;
          if (mem_ready) begin
            load_ir   = 1'b1;
            pc_inc    = 1'b1;
            stateNext = DECODE;
          end
        end
        DECODE: stateNext = EXEC;
        EXEC: begin
          do_sub = ir[ZBIT];
          for (int i = 0; i < NUM_SRC; i++) begin
            if (srcReg == SRC_W'(i)) src_n[i] = 1'b0;
          end
          if (isHaltDst) begin
            stateNext = HALT;
          end else if (!memSrc || mem_ready) begin
            // Final EXEC cycle: commit the destination and any immediate consume.
            stateNext = FETCH;
            pc_inc    = (srcReg == SRC_W'(SRC_ROM));
            flagLoad  = (dstReg == DST_W'(A_DEST));
            if (dstReg == DST_W'(PC_DEST)) begin
              load_en[PC_DEST] = jcond;
              do_jump          = jcond;
            end else begin
              for (int i = 1; i < NUM_DEST; i++) begin
                if (dstReg == DST_W'(i)) load_en[i] = 1'b1;
              end
            end
          end
        end
`ifdef CONTROL_SEQ_HALT_EN
        HALT:    stateNext = HALT;
`else
        HALT:    stateNext = FETCH;
`endif
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: a per-cycle instruction-level model queues
// expected outputs, and a negedge monitor compares them against the DUT.
module tb_control_seq;

`ifdef CONTROL_SEQ_HALT_EN
  localparam bit HALT_BUILD = 1'b1;
`else
  localparam bit HALT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       loadIr;
    logic       pcInc;
    logic [6:0] loadEn;
    logic [4:0] srcN;
    logic       doSub;
    logic       doJump;
    logic       flagC;
    logic       flagZ;
    logic       halted;
  } outVec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       mem_ready;
  logic       alu_zero;
  logic       alu_carry;
  logic       load_ir;
  logic       pc_inc;
  logic [6:0] load_en;
  logic [4:0] src_n;
  logic       do_sub;
  logic       do_jump;
  logic       flag_c;
  logic       flag_z;
  logic       halted;

  outVec_t expQ[$];
  string   tagQ[$];
  int      compared = 0;
  int      mismatched = 0;
  logic    mFlagC = 1'b0;
  logic    mFlagZ = 1'b0;

  control_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .load_ir   (load_ir),
    .pc_inc    (pc_inc),
    .load_en   (load_en),
    .src_n     (src_n),
    .do_sub    (do_sub),
    .do_jump   (do_jump),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic outVec_t idleVec();
    outVec_t v;
    v        = '0;
    v.srcN   = 5'h1f;
    v.flagC  = mFlagC;
    v.flagZ  = mFlagZ;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic mr, input logic ac,
                               input logic az, input outVec_t e, input string tag);
    reset     = rst;
    mem_ready = mr;
    alu_carry = ac;
    alu_zero  = az;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input outVec_t e, input string tag);
    outVec_t a;
    a = '{load_ir, pc_inc, load_en, src_n, do_sub, do_jump, flag_c, flag_z, halted};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got ldIr=%b pcInc=%b ldEn=%b srcN=%b sub=%b jmp=%b c=%b z=%b h=%b, expected ldIr=%b pcInc=%b ldEn=%b srcN=%b sub=%b jmp=%b c=%b z=%b h=%b",
               tag, a.loadIr, a.pcInc, a.loadEn, a.srcN, a.doSub, a.doJump, a.flagC, a.flagZ, a.halted,
               e.loadIr, e.pcInc, e.loadEn, e.srcN, e.doSub, e.doJump, e.flagC, e.flagZ, e.halted);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
    end
  end

  // One whole instruction: wF idle fetch cycles, wE memory-wait cycles in EXEC,
  // ALU outputs ac/az presented on the final EXEC cycle.
  task automatic runInstr(input logic [7:0] irv, input int wF, input int wE,
                          input logic ac, input logic az);
    outVec_t    e;
    logic [2:0] src;
    logic [2:0] dst;
    logic [4:0] srcMask;
    logic       memSrc;
    logic       halting;
    logic       jc;
    src     = irv[5:3];
    dst     = irv[2:0];
    srcMask = (src < 3'd5) ? 5'(~(32'd1 << src)) : 5'h1f;
    memSrc  = (src <= 3'd1);
    halting = HALT_BUILD && (dst == 3'd7);
    ir      = irv;
    for (int i = 0; i < wF; i++) begin
      e = idleVec(); e.srcN = 5'h1e;
      applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), e, "fetchWait");
    end
    e = idleVec(); e.srcN = 5'h1e; e.loadIr = 1'b1; e.pcInc = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'($urandom), 1'($urandom), e, "fetch");
    e = idleVec();
    applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), e, "decode");
    if (memSrc && !halting) begin
      for (int i = 0; i < wE; i++) begin
        e = idleVec(); e.srcN = srcMask; e.doSub = irv[6];
        applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), e, "execWait");
      end
    end
    e = idleVec(); e.srcN = srcMask; e.doSub = irv[6];
    if (!halting) begin
      e.pcInc = (src == 3'd0);
      if (dst == 3'd1) begin
        jc       = (irv[7] & irv[6]) | (irv[6] & mFlagZ) | (irv[7] & mFlagC);
        e.doJump = jc;
        e.loadEn = jc ? 7'b0000010 : 7'b0;
      end else if (dst >= 3'd1 && dst <= 3'd6) begin
        e.loadEn = 7'(32'd1 << dst);
      end
    end
    applyStimulus(1'b0, memSrc ? 1'b1 : 1'($urandom), ac, az, e, "execFinal");
    if (!halting && dst == 3'd2) begin
      mFlagC = ac;
      mFlagZ = az;
    end
    if (halting) begin
      for (int i = 0; i < 20; i++) begin
        e = idleVec(); e.halted = 1'b1;
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), e, "halted");
      end
    end
  endtask

  task automatic applyReset(input int n);
    outVec_t e;
    for (int i = 0; i < n; i++) begin
      e = idleVec();
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), e, "reset");
      mFlagC = 1'b0;
      mFlagZ = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] irv;
    outVec_t    e;
    reset     = 1'b1;
    ir        = 8'h00;
    mem_ready = 1'b0;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    @(posedge clk);
    #1;
    applyReset(1);

    runInstr(8'h12, 0, 0, 1'b0, 1'b0);
    runInstr(8'h0A, 1, 2, 1'b1, 1'b0);
    runInstr(8'h12, 0, 0, 1'b0, 1'b1);
    runInstr(8'h41, 0, 1, 1'b0, 1'b0);
    runInstr(8'h12, 0, 0, 1'b0, 1'b0);
    runInstr(8'h41, 0, 0, 1'b0, 1'b0);
    runInstr(8'hC1, 0, 0, 1'b0, 1'b0);
    runInstr(8'h12, 0, 0, 1'b1, 1'b0);
    runInstr(8'h81, 2, 0, 1'b0, 1'b0);

    // Reset while EXEC waits on memory, with flags previously set.
    runInstr(8'h12, 0, 0, 1'b1, 1'b1);
    ir = 8'h0A;
    e = idleVec(); e.srcN = 5'h1e; e.loadIr = 1'b1; e.pcInc = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, e, "fetch");
    e = idleVec();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, e, "decode");
    e = idleVec(); e.srcN = 5'h1d;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, e, "execWait");
    applyReset(1);
    runInstr(8'h12, 0, 0, 1'b0, 1'b1);

    runInstr(8'h17, 0, 0, 1'b1, 1'b1);
    if (HALT_BUILD) applyReset(2);
    runInstr(8'h0A, 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      irv = 8'($urandom_range(0, 255));
      if (HALT_BUILD && irv[2:0] == 3'd7) irv[2:0] = 3'd6;
      runInstr(irv, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
